// File: rtl/pipe_rca_addsub_if.sv
// Operand/result handshake bundle for pipe_rca_addsub.
// master = operand source + result consumer side, slave = the adder pipeline.
interface pipe_rca_addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipe_rca_addsub.sv
// Pipelined ripple-carry add/sub: one CHUNK-bit slice per stage, carry registered between stages.
// Latency STAGES cycles; out_ready low freezes every stage at once (in_ready = !out_valid || out_ready).
module pipe_rca_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   pipe_rca_addsub_if.slave io
);
   localparam int SDIV  = (STAGES < 1) ? 1 : STAGES;
   localparam int CHUNK = WIDTH / SDIV;

   if ((STAGES < 1) || ((WIDTH % SDIV) != 0)) begin : g_param_check
      $error("pipe_rca_addsub: STAGES must be >= 1 and divide WIDTH");
   end

   logic [WIDTH-1:0] r_a [STAGES];
   logic [WIDTH-1:0] r_b [STAGES];
   logic [WIDTH-1:0] r_s [STAGES];
   logic             r_c [STAGES];
   logic             r_v [STAGES];
   logic             r_ovf;

   logic [WIDTH-1:0] w_a_src [STAGES];
   logic [WIDTH-1:0] w_b_src [STAGES];
   logic [WIDTH-1:0] w_s_src [STAGES];
   logic [WIDTH-1:0] w_s_nxt [STAGES];
   logic             w_c_src [STAGES];
   logic             w_v_src [STAGES];
   logic [CHUNK:0]   w_add   [STAGES];
   logic             w_adv;
   logic             w_ovf_nxt;

   assign w_adv       = !r_v[STAGES-1] || io.out_ready;
   assign io.in_ready = w_adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] SLICE = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

      // B is conditioned once at entry; borrow-in becomes carry-in via cin ^ sub.
      if (k == 0) begin : g_first
         assign w_a_src[k] = io.a;
         assign w_b_src[k] = io.b ^ {WIDTH{io.sub}};
         assign w_s_src[k] = '0;
         assign w_c_src[k] = io.cin ^ io.sub;
         assign w_v_src[k] = io.in_valid;
      end else begin : g_next
         assign w_a_src[k] = r_a[k-1];
         assign w_b_src[k] = r_b[k-1];
         assign w_s_src[k] = r_s[k-1];
         assign w_c_src[k] = r_c[k-1];
         assign w_v_src[k] = r_v[k-1];
      end

      assign w_add[k]   = {1'b0, w_a_src[k][k*CHUNK +: CHUNK]}
                        + {1'b0, w_b_src[k][k*CHUNK +: CHUNK]}
                        + {{CHUNK{1'b0}}, w_c_src[k]};
      assign w_s_nxt[k] = (w_s_src[k] & ~SLICE) | (WIDTH'(w_add[k][CHUNK-1:0]) << (k * CHUNK));
   end

   // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
   assign w_ovf_nxt = w_a_src[STAGES-1][WIDTH-1] ^ w_b_src[STAGES-1][WIDTH-1]
                    ^ w_s_nxt[STAGES-1][WIDTH-1] ^ w_add[STAGES-1][CHUNK];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k] <= 1'b0;
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k] <= w_v_src[k];
            r_a[k] <= w_a_src[k];
            r_b[k] <= w_b_src[k];
            r_s[k] <= w_s_nxt[k];
            r_c[k] <= w_add[k][CHUNK];
         end
         r_ovf <= w_ovf_nxt;
      end
   end

   assign io.out_valid = r_v[STAGES-1];
   assign io.sum       = r_s[STAGES-1];
   assign io.cout      = r_c[STAGES-1];
   assign io.ovf       = r_ovf;
endmodule

// File: tb/tb_pipe_rca_addsub.sv
// Bench for pipe_rca_addsub: directed vectors on a 4-stage instance, plus a 1-stage and a
// 16-stage instance streamed side by side against an a +/- b +/- cin model.
module tb_pipe_rca_addsub;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pipe_rca_addsub_if #(.WIDTH(16)) if4 ();
   pipe_rca_addsub_if #(.WIDTH(16)) if1 ();
   pipe_rca_addsub_if #(.WIDTH(16)) if16 ();

   pipe_rca_addsub #(.WIDTH(16), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .io(if4));
   pipe_rca_addsub #(.WIDTH(16), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .io(if1));
   pipe_rca_addsub #(.WIDTH(16), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .io(if16));

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int          t;
   } exp_t;

   // Issue one operation on the 4-stage instance and wait (bounded) for its result.
   task automatic run_one4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic sub, output logic [15:0] s, output logic c,
                           output logic o, output int lat);
      @(negedge clk);
      if4.a = a; if4.b = b; if4.cin = cin; if4.sub = sub;
      if4.in_valid = 1'b1; if4.out_ready = 1'b1;
      @(negedge clk);
      if4.in_valid = 1'b0;
      lat = 1;
      while (if4.out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      s = if4.sum; c = if4.cout; o = if4.ovf;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if4.in_valid = 1'b1; if4.a = 16'hFFFF; if4.b = 16'h0001; if4.cin = 1'b0; if4.sub = 1'b0;
      if4.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.sub = 1'b0; if1.out_ready = 1'b1;
      if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.sub = 1'b0; if16.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid got %b want 0", if4.out_valid); end
      n_cmp++; if (if4.sum !== 16'h0000) begin n_err++; $display("FAIL reset.sum got %h want 0000", if4.sum); end
      n_cmp++; if (if4.cout !== 1'b0) begin n_err++; $display("FAIL reset.cout got %b want 0", if4.cout); end
      n_cmp++; if (if4.ovf !== 1'b0) begin n_err++; $display("FAIL reset.ovf got %b want 0", if4.ovf); end
      n_cmp++; if (if1.out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid_s1 got %b want 0", if1.out_valid); end
      n_cmp++; if (if16.out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid_s16 got %b want 0", if16.out_valid); end
      rst = 1'b0;
      if4.in_valid = 1'b0;
      #1;
      n_cmp++; if (if4.in_ready !== 1'b1) begin n_err++; $display("FAIL reset.in_ready got %b want 1", if4.in_ready); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (if4.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset.no_accept_during_rst cycle %0d got out_valid %b want 0", i, if4.out_valid);
         end
      end
   endtask

   task automatic test_add_basic();
      logic [15:0] s; logic c, o; int lat;
      run_one4(16'h1234, 16'h1111, 1'b0, 1'b0, s, c, o, lat);
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL add_basic.latency got %0d want 4", lat); end
      n_cmp++; if (s !== 16'h2345) begin n_err++; $display("FAIL add_basic.sum got %h want 2345", s); end
      n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL add_basic.cout got %b want 0", c); end
      n_cmp++; if (o !== 1'b0) begin n_err++; $display("FAIL add_basic.ovf got %b want 0", o); end
   endtask

   task automatic test_carry_chain();
      logic [15:0] s; logic c, o; int lat;
      run_one4(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL carry_chain.latency got %0d want 4", lat); end
      n_cmp++; if (s !== 16'h0000) begin n_err++; $display("FAIL carry_chain.sum got %h want 0000", s); end
      n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL carry_chain.cout got %b want 1", c); end
      n_cmp++; if (o !== 1'b0) begin n_err++; $display("FAIL carry_chain.ovf got %b want 0", o); end
      run_one4(16'hFFFF, 16'h0000, 1'b1, 1'b0, s, c, o, lat);
      n_cmp++; if (s !== 16'h0000) begin n_err++; $display("FAIL carry_cin.sum got %h want 0000", s); end
      n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL carry_cin.cout got %b want 1", c); end
   endtask

   task automatic test_sub_ovf();
      logic [15:0] va [4], vb [4], vs [4];
      logic        vc [4], vsub [4], vco [4], vov [4];
      logic [15:0] s; logic c, o; int lat;
      va = '{16'h7FFF, 16'h0000, 16'h0005, 16'h8000};
      vb = '{16'h0001, 16'h0001, 16'h0003, 16'h0001};
      vc = '{1'b0, 1'b0, 1'b1, 1'b0};
      vsub = '{1'b0, 1'b1, 1'b1, 1'b1};
      vs = '{16'h8000, 16'hFFFF, 16'h0001, 16'h7FFF};
      vco = '{1'b0, 1'b0, 1'b1, 1'b1};
      vov = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         run_one4(va[i], vb[i], vc[i], vsub[i], s, c, o, lat);
         n_cmp++; if (s !== vs[i]) begin n_err++; $display("FAIL sub_ovf[%0d].sum got %h want %h", i, s, vs[i]); end
         n_cmp++; if (c !== vco[i]) begin n_err++; $display("FAIL sub_ovf[%0d].cout got %b want %b", i, c, vco[i]); end
         n_cmp++; if (o !== vov[i]) begin n_err++; $display("FAIL sub_ovf[%0d].ovf got %b want %b", i, o, vov[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ta [8], tb [8], ts [8];
      logic        tc [8], tsub [8], tco [8], tov [8];
      logic [18:0] held;
      logic        stalled_prev;
      int          nsent, nrx;
      ta   = '{16'h0001, 16'h00FF, 16'hFFFF, 16'h1000, 16'h8000, 16'h0003, 16'hABCD, 16'h7000};
      tb   = '{16'h0002, 16'h0001, 16'hFFFF, 16'h0001, 16'h8000, 16'h0005, 16'h1234, 16'h9000};
      tc   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tsub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      ts   = '{16'h0003, 16'h0101, 16'hFFFE, 16'h0FFF, 16'h0000, 16'hFFFE, 16'hBE02, 16'hE000};
      tco  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      nsent = 0; nrx = 0; stalled_prev = 1'b0; held = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if4.out_ready = !(c >= 5 && c <= 7);
         #1;
         if (c == 5) begin
            n_cmp++; if (if4.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b.valid_at_stall got %b want 1", if4.out_valid); end
         end
         if (!if4.out_ready) begin
            n_cmp++;
            if (if4.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b.in_ready_stall cycle %0d got %b want 0", c, if4.in_ready); end
            if (stalled_prev) begin
               n_cmp++;
               if ({if4.out_valid, if4.sum, if4.cout, if4.ovf} !== held) begin
                  n_err++; $display("FAIL b2b.hold cycle %0d got %h want %h", c, {if4.out_valid, if4.sum, if4.cout, if4.ovf}, held);
               end
            end
            held = {if4.out_valid, if4.sum, if4.cout, if4.ovf};
            stalled_prev = 1'b1;
         end else begin
            stalled_prev = 1'b0;
         end
         if (if4.out_valid === 1'b1 && if4.out_ready) begin
            n_cmp++;
            if (nrx >= 8) begin
               n_err++; $display("FAIL b2b.extra_result got %h want none", if4.sum);
            end else begin
               if ({if4.sum, if4.cout, if4.ovf} !== {ts[nrx], tco[nrx], tov[nrx]}) begin
                  n_err++; $display("FAIL b2b.result[%0d] got %h/%b/%b want %h/%b/%b", nrx,
                                    if4.sum, if4.cout, if4.ovf, ts[nrx], tco[nrx], tov[nrx]);
               end
               nrx++;
            end
         end
         if (nsent < 8) begin
            if4.a = ta[nsent]; if4.b = tb[nsent]; if4.cin = tc[nsent]; if4.sub = tsub[nsent];
            if4.in_valid = 1'b1;
            if (if4.in_ready === 1'b1) nsent++;
         end else begin
            if4.in_valid = 1'b0;
         end
      end
      n_cmp++; if (nrx !== 8) begin n_err++; $display("FAIL b2b.count got %0d want 8", nrx); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] xa [3], xb [3];
      xa = '{16'h1111, 16'hFFFF, 16'h7FFF};
      xb = '{16'h2222, 16'hFFFF, 16'h0001};
      if4.out_ready = 1'b1; if4.cin = 1'b0; if4.sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if4.a = xa[i]; if4.b = xb[i]; if4.in_valid = 1'b1;
      end
      @(negedge clk);
      if4.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid.out_valid got %b want 0", if4.out_valid); end
      n_cmp++; if (if4.sum !== 16'h0000) begin n_err++; $display("FAIL reset_mid.sum got %h want 0000", if4.sum); end
      n_cmp++; if ({if4.cout, if4.ovf} !== 2'b00) begin n_err++; $display("FAIL reset_mid.flags got %b want 00", {if4.cout, if4.ovf}); end
      n_cmp++; if (if4.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid.in_ready got %b want 1", if4.in_ready); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_cmp++;
         if (if4.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_mid.stale cycle %0d got out_valid %b sum %h want 0", i, if4.out_valid, if4.sum);
         end
      end
   endtask

   task automatic test_regress();
      exp_t        q1 [$], q16 [$];
      exp_t        e;
      logic [15:0] ra, rb;
      logic        rc, rs;
      logic [16:0] full;
      int          sent;
      sent = 0;
      for (int it = 0; it < 1100; it++) begin
         @(negedge clk);
         if (if1.out_valid === 1'b1) begin
            n_cmp++;
            if (q1.size() == 0) begin
               n_err++; $display("FAIL regress_s1.spurious got %h want none", if1.sum);
            end else begin
               e = q1.pop_front();
               if ({if1.sum, if1.cout, if1.ovf} !== {e.sum, e.cout, e.ovf}) begin
                  n_err++; $display("FAIL regress_s1.result got %h/%b/%b want %h/%b/%b",
                                    if1.sum, if1.cout, if1.ovf, e.sum, e.cout, e.ovf);
               end
               n_cmp++;
               if (it - e.t !== 1) begin n_err++; $display("FAIL regress_s1.latency got %0d want 1", it - e.t); end
            end
         end
         if (if16.out_valid === 1'b1) begin
            n_cmp++;
            if (q16.size() == 0) begin
               n_err++; $display("FAIL regress_s16.spurious got %h want none", if16.sum);
            end else begin
               e = q16.pop_front();
               if ({if16.sum, if16.cout, if16.ovf} !== {e.sum, e.cout, e.ovf}) begin
                  n_err++; $display("FAIL regress_s16.result got %h/%b/%b want %h/%b/%b",
                                    if16.sum, if16.cout, if16.ovf, e.sum, e.cout, e.ovf);
               end
               n_cmp++;
               if (it - e.t !== 16) begin n_err++; $display("FAIL regress_s16.latency got %0d want 16", it - e.t); end
            end
         end
         if (sent < 1000) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(1, 0)); rs = 1'($urandom_range(1, 0));
            if (!rs) full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            else     full = {1'b0, ra} + {1'b0, ~rb} + {16'b0, ~rc};
            e.sum  = full[15:0];
            e.cout = full[16];
            e.ovf  = rs ? ((ra[15] != rb[15]) && (full[15] != ra[15]))
                        : ((ra[15] == rb[15]) && (full[15] != ra[15]));
            e.t    = it;
            q1.push_back(e);
            q16.push_back(e);
            if1.a = ra;  if1.b = rb;  if1.cin = rc;  if1.sub = rs;  if1.in_valid = 1'b1;
            if16.a = ra; if16.b = rb; if16.cin = rc; if16.sub = rs; if16.in_valid = 1'b1;
            sent++;
         end else begin
            if1.in_valid = 1'b0;
            if16.in_valid = 1'b0;
         end
      end
      n_cmp++; if (q1.size() !== 0) begin n_err++; $display("FAIL regress_s1.missing got %0d left want 0", q1.size()); end
      n_cmp++; if (q16.size() !== 0) begin n_err++; $display("FAIL regress_s16.missing got %0d left want 0", q16.size()); end
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_carry_chain();
      test_sub_ovf();
      test_back_to_back();
      test_reset_mid();
      test_regress();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
